// File: rtl/nv_arb2_mux_ctrl.sv
// nv_arb2_mux_ctrl: two-port packet arbiter driving one downstream
// valid/ready stream. Packet-locked weighted round-robin; the datapath is
// combinational from the registered grant, so no beat is stored here.
//
// state | meaning
// IDLE  | no grant; waiting for a requester
// GNT0  | port 0 owns the output
// GNT1  | port 1 owns the output
module nv_arb2_mux_ctrl #(
  parameter int DW  = 32,
  parameter int WTW = 4
) (
  input  logic           nvdla_core_clk,
  input  logic           nvdla_core_rst,
  input  logic [WTW-1:0] cfg_wt0,
  input  logic [WTW-1:0] cfg_wt1,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_pd,
  input  logic           req0_last,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_pd,
  input  logic           req1_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_pd,
  output logic           out_last,
  output logic           arb_sel,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t         state;
  logic           pkt_open;
  logic [WTW-1:0] cnt;
  logic           last_served;

  logic           g0;
  logic           g1;
  logic           oth_valid;
  logic [WTW-1:0] cur_wt;
  logic [WTW-1:0] eff_wt;
  logic [WTW:0]   cnt_inc;
  logic           turn_done;
  logic           accept;

  // Grant-dependent datapath and turn bookkeeping, all from registered state.
  always_comb begin
    g0         = (state == GNT0);
    g1         = (state == GNT1);
    out_valid  = (g0 & req0_valid) | (g1 & req1_valid);
    out_last   = (g0 & req0_last) | (g1 & req1_last);
    out_pd     = arb_sel ? req1_pd : req0_pd;
    req0_ready = g0 & out_ready;
    req1_ready = g1 & out_ready;
    busy       = pkt_open;
    oth_valid  = g0 ? req1_valid : req0_valid;
    cur_wt     = g1 ? cfg_wt1 : cfg_wt0;
    eff_wt     = (cur_wt == '0) ? WTW'(1) : cur_wt;
    cnt_inc    = {1'b0, cnt} + {{WTW{1'b0}}, 1'b1};
    turn_done  = (cnt_inc >= {1'b0, eff_wt});
    accept     = out_valid & out_ready;
  end

  // Grant FSM: packet lock, weighted turns, and registered mux select.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state       <= IDLE;
      arb_sel     <= 1'b0;
      pkt_open    <= 1'b0;
      cnt         <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0_valid && req1_valid) begin
            state   <= last_served ? GNT0 : GNT1;
            arb_sel <= ~last_served;
          end else if (req0_valid) begin
            state   <= GNT0;
            arb_sel <= 1'b0;
          end else if (req1_valid) begin
            state   <= GNT1;
            arb_sel <= 1'b1;
          end
        end
        GNT0, GNT1: begin
          if (accept) begin
            if (!out_last) begin
              pkt_open <= 1'b1;
            end else begin
              pkt_open <= 1'b0;
              if (!turn_done) begin
                cnt <= (&cnt) ? cnt : cnt_inc[WTW-1:0];
              end else begin
                cnt <= '0;
                if (oth_valid) begin
                  state       <= g0 ? GNT1 : GNT0;
                  arb_sel     <= g0;
                  last_served <= g1;
                end
              end
            end
          end else if (!pkt_open && !out_valid) begin
            // Owner went quiet between packets: hand over or go idle.
            cnt         <= '0;
            last_served <= g1;
            if (oth_valid) begin
              state   <= g0 ? GNT1 : GNT0;
              arb_sel <= g0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state    <= IDLE;
          pkt_open <= 1'b0;
          cnt      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nv_arb2_mux_ctrl.sv
// Bench for nv_arb2_mux_ctrl: directed packet streams, a turn-level model
// compared every cycle, plus literal expectations for the key scenarios.
module tb_nv_arb2_mux_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_wt0 = 4'd1, cfg_wt1 = 4'd1;
  logic        req0_valid = 1'b0, req0_last = 1'b0;
  logic        req1_valid = 1'b0, req1_last = 1'b0;
  logic [31:0] req0_pd = '0, req1_pd = '0;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_last, arb_sel, busy;
  logic        out_ready = 1'b0;
  logic [31:0] out_pd;

  nv_arb2_mux_ctrl #(.DW(32), .WTW(4)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .cfg_wt0(cfg_wt0), .cfg_wt1(cfg_wt1),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pd(req0_pd), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pd(req1_pd), .req1_last(req1_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pd(out_pd), .out_last(out_last),
    .arb_sel(arb_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pd; logic last; } beat_t;
  typedef struct { int port; logic [31:0] pd; int cyc; } log_t;

  beat_t       q0[$], q1[$];
  logic [31:0] e0[$], e1[$];
  log_t        lg[$];

  int checks = 0, failures = 0, cyc = 0;
  bit chk_en = 1'b0;

  // Model: who owns the output, whether a packet is mid-flight, how many
  // packets the owner finished this turn, who finished a turn last.
  int m_owner, m_done, m_prev, m_sel;
  bit m_open;
  int n_owner, n_done, n_prev, n_sel;
  bit n_open;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    m_owner = -1; m_done = 0; m_prev = 1; m_sel = 0; m_open = 1'b0;
  endtask

  task automatic model_step();
    bit v[2], l[2];
    int wt[2], p, o, w;
    v[0] = req0_valid; v[1] = req1_valid;
    l[0] = req0_last;  l[1] = req1_last;
    wt[0] = int'(cfg_wt0); wt[1] = int'(cfg_wt1);
    n_owner = m_owner; n_done = m_done; n_prev = m_prev; n_sel = m_sel; n_open = m_open;
    if (m_owner < 0) begin
      n_done = 0;
      if (v[0] && v[1]) n_owner = 1 - m_prev;
      else if (v[0])    n_owner = 0;
      else if (v[1])    n_owner = 1;
    end else begin
      p = m_owner; o = 1 - p;
      if (v[p] && out_ready) begin
        if (!l[p]) n_open = 1'b1;
        else begin
          n_open = 1'b0;
          w = (wt[p] == 0) ? 1 : wt[p];
          if (m_done + 1 < w) n_done = m_done + 1;
          else begin
            n_done = 0;
            if (v[o]) begin n_owner = o; n_prev = p; end
          end
        end
      end else if (!m_open && !v[p]) begin
        n_done = 0; n_prev = p;
        n_owner = v[o] ? o : -1;
      end
    end
    if (n_owner >= 0) n_sel = n_owner;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      logic ev, el;
      ev = (m_owner == 0) ? req0_valid : (m_owner == 1) ? req1_valid : 1'b0;
      el = (m_owner == 0) ? req0_last  : (m_owner == 1) ? req1_last  : 1'b0;
      chk("out_valid", 64'(out_valid), 64'(ev));
      chk("out_last", 64'(out_last), 64'(el));
      chk("out_pd", 64'(out_pd), 64'((m_sel == 1) ? req1_pd : req0_pd));
      chk("req0_ready", 64'(req0_ready), 64'((m_owner == 0) && out_ready));
      chk("req1_ready", 64'(req1_ready), 64'((m_owner == 1) && out_ready));
      chk("arb_sel", 64'(arb_sel), 64'(m_sel));
      chk("busy", 64'(busy), 64'(m_open));
    end
  end

  task automatic drive();
    req0_valid = (q0.size() > 0);
    req0_pd    = (q0.size() > 0) ? q0[0].pd : '0;
    req0_last  = (q0.size() > 0) ? q0[0].last : 1'b0;
    req1_valid = (q1.size() > 0);
    req1_pd    = (q1.size() > 0) ? q1[0].pd : '0;
    req1_last  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  task automatic push_pkt(int port, int nb, logic [31:0] base);
    beat_t b;
    for (int i = 0; i < nb; i++) begin
      b.pd = base + 32'(i); b.last = (i == nb - 1);
      if (port == 0) begin q0.push_back(b); e0.push_back(b.pd); end
      else           begin q1.push_back(b); e1.push_back(b.pd); end
    end
  endtask

  task automatic cycle();
    bit a0, a1;
    log_t e;
    @(negedge clk);
    model_step();
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    if (out_valid && out_ready) begin
      e.port = int'(arb_sel); e.pd = out_pd; e.cyc = cyc;
      lg.push_back(e);
    end
    @(posedge clk); #1;
    m_owner = n_owner; m_done = n_done; m_prev = n_prev; m_sel = n_sel; m_open = n_open;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    cyc++;
    drive();
    #1;
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); e0.delete(); e1.delete(); lg.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b0;
    clear_all(); model_init(); drive();
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_arb_sel", 64'(arb_sel), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
  endtask

  task automatic drain(int maxc);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < maxc) begin cycle(); k++; end
    chk("drain_remaining", 64'(q0.size() + q1.size()), 64'd0);
    cycle(); cycle();
  endtask

  task automatic check_order();
    for (int i = 0; i < lg.size(); i++) begin
      if (lg[i].port == 0) begin
        if (e0.size() > 0) chk("order_p0", 64'(lg[i].pd), 64'(e0.pop_front()));
        else chk("extra_p0", 64'(lg[i].pd), 64'hFFFF_FFFF_FFFF);
      end else begin
        if (e1.size() > 0) chk("order_p1", 64'(lg[i].pd), 64'(e1.pop_front()));
        else chk("extra_p1", 64'(lg[i].pd), 64'hFFFF_FFFF_FFFF);
      end
    end
    chk("missing_beats", 64'(e0.size() + e1.size()), 64'd0);
  endtask

  task automatic check_pattern(string name, int n, logic [15:0] pat);
    chk({name, "_len"}, 64'(lg.size() >= n), 64'd1);
    for (int i = 0; i < n && i < lg.size(); i++)
      chk(name, 64'(lg[i].port), 64'(pat[i]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    model_init();
    drive();
    repeat (2) @(posedge clk);
    chk_en = 1'b1;

    // T1: single-beat packet on port 0
    do_reset();
    out_ready = 1'b1;
    push_pkt(0, 1, 32'hA0); drive(); #1;
    chk("t1_idle_out_valid", 64'(out_valid), 64'd0);
    cycle();
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_pd", 64'(out_pd), 64'hA0);
    chk("t1_req0_ready", 64'(req0_ready), 64'd1);
    chk("t1_req1_ready", 64'(req1_ready), 64'd0);
    drain(10); check_order();

    // T2: weights 2:1, continuous single-beat packets
    do_reset();
    cfg_wt0 = 4'd2; cfg_wt1 = 4'd1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin push_pkt(0, 1, 32'h000 + 32'(i)); push_pkt(1, 1, 32'h100 + 32'(i)); end
    drive(); #1;
    drain(60);
    check_pattern("t2_src", 6, 16'b100100);
    for (int i = 1; i < lg.size(); i++) chk("t2_no_bubble", 64'(lg[i].cyc), 64'(lg[0].cyc + i));
    chk("t2_total", 64'(lg.size()), 64'd12);
    check_order();

    // T3: 4-beat packet locks the grant under toggling out_ready
    do_reset();
    cfg_wt0 = 4'd1; cfg_wt1 = 4'd1;
    push_pkt(0, 4, 32'h10); push_pkt(1, 1, 32'h110); drive(); #1;
    k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < 40) begin out_ready = (k % 2 == 0); #1; cycle(); k++; end
    out_ready = 1'b1; #1;
    drain(10);
    check_pattern("t3_src", 5, 16'b10000);
    check_order();

    // T4: backpressure mid-packet
    do_reset();
    out_ready = 1'b1;
    push_pkt(0, 3, 32'h20); drive(); #1;
    k = 0;
    while (lg.size() < 1 && k < 20) begin cycle(); k++; end
    out_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i == 2) begin
        chk("t4_stall_valid", 64'(out_valid), 64'd1);
        chk("t4_stall_ready", 64'(req0_ready), 64'd0);
        chk("t4_stall_pd", 64'(out_pd), 64'h21);
        chk("t4_stall_busy", 64'(busy), 64'd1);
      end
    end
    out_ready = 1'b1; #1;
    drain(20);
    chk("t4_total", 64'(lg.size()), 64'd3);
    check_order();

    // T5: zero weights behave as one
    do_reset();
    cfg_wt0 = 4'd0; cfg_wt1 = 4'd0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin push_pkt(0, 1, 32'h30 + 32'(i)); push_pkt(1, 1, 32'h130 + 32'(i)); end
    drive(); #1;
    drain(40);
    check_pattern("t5_src", 8, 16'b10101010);
    check_order();

    // T6: reset in the middle of a 3-beat packet
    do_reset();
    cfg_wt0 = 4'd1; cfg_wt1 = 4'd1; out_ready = 1'b1;
    push_pkt(0, 3, 32'h40); push_pkt(1, 1, 32'h140); drive(); #1;
    k = 0;
    while (lg.size() < 1 && k < 20) begin cycle(); k++; end
    chk("t6_busy_before", 64'(busy), 64'd1);
    rst = 1'b1; #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_arb_sel", 64'(arb_sel), 64'd0);
    clear_all(); model_init();
    push_pkt(0, 1, 32'h50); push_pkt(1, 1, 32'h150); drive();
    @(posedge clk); #1;
    rst = 1'b0; #1;
    drain(20);
    check_pattern("t6_first", 2, 16'b10);
    if (lg.size() > 0) chk("t6_first_pd", 64'(lg[0].pd), 64'h50);
    check_order();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
